// File: rtl/fechadura_pkg.sv
// +--------------------------------------------------------------------------+
// | fechadura_pkg : shared types, constants and password helpers for the     |
// |                 door-lock controller family.                             |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

package fechadura_pkg;

  localparam int N_SENHAS_MAX  = 4;
  localparam int N_DIGITOS_MAX = 12;

  typedef logic [N_DIGITOS_MAX-1:0][3:0] senhaPac_t;
  typedef logic [5:0][3:0]               bcdPac_t;

  typedef struct packed {
    logic                            bip_status;
    logic [15:0]                     bip_time;
    logic [15:0]                     tranca_aut_time;
    senhaPac_t                       senha_master;
    senhaPac_t [N_SENHAS_MAX-1:0]    senha_usr;
  } setupPac_t;

  typedef enum logic [2:0] {
    TRAVADO            = 3'd0,
    BLOQUEADO          = 3'd1,
    DESTRAVADO_FECHADO = 3'd2,
    PORTA_ABERTA       = 3'd3,
    SETUP              = 3'd4
  } estado_t;

  localparam senhaPac_t SENHA_VAZIA      = '1;
  localparam senhaPac_t SENHA_MASTER_DEF = {32'hFFFF_FFFF, 16'h1234};

  // Only the lowest n digits take part in a comparison.
  function automatic logic senha_igual(senhaPac_t a, senhaPac_t b, int n);
    logic r;
    r = 1'b1;
    for (int i = 0; i < N_DIGITOS_MAX; i++)
      if (i < n && a[i] != b[i]) r = 1'b0;
    return r;
  endfunction

  // A slot whose compared digits are all 4'hF is disabled.
  function automatic logic senha_ativa(senhaPac_t s, int n);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_DIGITOS_MAX; i++)
      if (i < n && s[i] != 4'hF) r = 1'b1;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_2dig.sv
// +--------------------------------------------------------------------------+
// | bin2bcd_2dig : 7-bit binary, clamped to 99, to two BCD digits.           |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module bin2bcd_2dig (
  input  logic [6:0] i_bin,
  output logic [3:0] o_dez,
  output logic [3:0] o_uni
);

  logic [6:0] w_val;

  assign w_val = (i_bin > 7'd99) ? 7'd99 : i_bin;
  assign o_dez = 4'(w_val / 7'd10);
  assign o_uni = 4'(w_val % 7'd10);

endmodule

`default_nettype wire

// File: rtl/operacional_multi.sv
// +--------------------------------------------------------------------------+
// | operacional_multi : multi-password door-lock controller with timed       |
// |                     keypad lockout. Macro ESCALONAMENTO_BLOQUEIO_EN      |
// |                     doubles the lockout on each repeat (up to x8).       |
// | Revision          : 1.0                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module operacional_multi
  import fechadura_pkg::*;
#(
  parameter int N_SENHAS       = 2,
  parameter int N_DIGITOS      = 4,
  parameter int MAX_TENTATIVAS = 3,
  parameter int BLOQ_CICLOS    = 30000,
  parameter int UNID_CICLOS    = 1000,
  parameter int TRANCA_AUT_DEF = 5000,
  parameter int BIP_TIME_DEF   = 5000
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      sensor_contato,
  input  logic      botao_interno,
  input  logic      botao_bloqueio,
  input  logic      botao_config,
  input  setupPac_t data_setup_new,
  input  logic      data_setup_ok,
  input  senhaPac_t digitos_value,
  input  logic      digitos_valid,
  output bcdPac_t   bcd_pac,
  output logic      teclado_en,
  output logic      display_en,
  output logic      setup_on,
  output logic      tranca,
  output logic      bip
);

  localparam setupPac_t C_SETUP_DEF = {1'b1, 16'(BIP_TIME_DEF), 16'(TRANCA_AUT_DEF),
                                       SENHA_MASTER_DEF, {N_SENHAS_MAX{SENHA_VAZIA}}};

  estado_t     r_estado, w_prox;
  setupPac_t   r_setup;
  logic        r_ini, r_master, w_master_n;
  logic [3:0]  r_falhas, w_falhas_n;
  logic [4:0]  w_falhas_inc;
  logic [15:0] r_tmr, w_tmr_n;
  logic [23:0] r_rem, w_rem_n, w_dur;
  logic        w_rst, w_match_master, w_match_usr;
  logic        r_tranca, r_teclado, r_display, r_setup_on, r_bip;
  bcdPac_t     r_bcd, w_bcd_n;
  logic [24:0] w_unid;
  logic [6:0]  w_unid_sat;
  logic [3:0]  w_dez, w_uni;

  // The first edge after release still behaves as reset.
  assign w_rst = !rst || !r_ini;

`ifdef ESCALONAMENTO_BLOQUEIO_EN
  logic [1:0] r_n_bloq, w_n_bloq_n;
  assign w_dur = 24'(BLOQ_CICLOS) << r_n_bloq;
`else
  assign w_dur = 24'(BLOQ_CICLOS);
`endif

  assign w_match_master = senha_igual(digitos_value, r_setup.senha_master, N_DIGITOS);
  assign w_falhas_inc   = {1'b0, r_falhas} + 5'd1;

  always_comb begin
    w_match_usr = 1'b0;
    for (int s = 0; s < N_SENHAS_MAX; s++)
      if (s < N_SENHAS && senha_ativa(r_setup.senha_usr[s], N_DIGITOS) &&
          senha_igual(digitos_value, r_setup.senha_usr[s], N_DIGITOS))
        w_match_usr = 1'b1;
  end

  always_comb begin
    w_prox     = r_estado;
    w_falhas_n = r_falhas;
    w_tmr_n    = r_tmr;
    w_rem_n    = r_rem;
    w_master_n = r_master;
`ifdef ESCALONAMENTO_BLOQUEIO_EN
    w_n_bloq_n = r_n_bloq;
`endif
    case (r_estado)
      TRAVADO: begin
        if (botao_interno) begin
          w_prox     = DESTRAVADO_FECHADO;
          w_tmr_n    = '0;
          w_master_n = 1'b0;
        end else if (digitos_valid) begin
          if (w_match_master || w_match_usr) begin
            w_prox     = DESTRAVADO_FECHADO;
            w_tmr_n    = '0;
            w_falhas_n = '0;
            w_master_n = w_match_master;
`ifdef ESCALONAMENTO_BLOQUEIO_EN
            w_n_bloq_n = 2'd0;
`endif
          end else if (w_falhas_inc >= 5'(MAX_TENTATIVAS)) begin
            w_prox     = BLOQUEADO;
            w_falhas_n = '0;
            w_rem_n    = w_dur;
`ifdef ESCALONAMENTO_BLOQUEIO_EN
            if (r_n_bloq != 2'd3) w_n_bloq_n = r_n_bloq + 2'd1;
`endif
          end else begin
            w_falhas_n = w_falhas_inc[3:0];
          end
        end
      end
      BLOQUEADO: begin
        if (botao_interno) begin
          w_prox     = DESTRAVADO_FECHADO;
          w_tmr_n    = '0;
          w_master_n = 1'b0;
        end else if (r_rem == '0) begin
          w_prox = TRAVADO;
        end else begin
          w_rem_n = r_rem - 24'd1;
        end
      end
      DESTRAVADO_FECHADO: begin
        if (botao_bloqueio) begin
          w_prox = TRAVADO;
        end else if (!sensor_contato) begin
          w_prox  = PORTA_ABERTA;
          w_tmr_n = '0;
        end else if (botao_config && r_master) begin
          w_prox = SETUP;
        end else if ({1'b0, r_tmr} + 17'd1 >= {1'b0, r_setup.tranca_aut_time}) begin
          w_prox = TRAVADO;
        end else begin
          w_tmr_n = r_tmr + 16'd1;
        end
      end
      PORTA_ABERTA: begin
        if (sensor_contato) begin
          w_prox  = DESTRAVADO_FECHADO;
          w_tmr_n = '0;
        end else if (r_tmr != '1) begin
          w_tmr_n = r_tmr + 16'd1;
        end
      end
      SETUP: begin
        if (data_setup_ok) begin
          w_prox  = DESTRAVADO_FECHADO;
          w_tmr_n = '0;
        end
      end
      default: w_prox = TRAVADO;
    endcase
  end

  // Remaining lockout shown in display units, rounded up.
  assign w_unid     = (25'(w_rem_n) + 25'(UNID_CICLOS - 1)) / 25'(UNID_CICLOS);
  assign w_unid_sat = (w_unid > 25'd99) ? 7'd99 : w_unid[6:0];

  bin2bcd_2dig u_bcd (
    .i_bin (w_unid_sat),
    .o_dez (w_dez),
    .o_uni (w_uni)
  );

  assign w_bcd_n = (w_prox == BLOQUEADO) ? {16'hFFFF, w_dez, w_uni} : '1;

  always_ff @(posedge clk) begin
    r_ini <= rst;
    if (w_rst) begin
      r_estado   <= TRAVADO;
      r_setup    <= C_SETUP_DEF;
      r_falhas   <= '0;
      r_tmr      <= '0;
      r_rem      <= '0;
      r_master   <= 1'b0;
      r_tranca   <= 1'b1;
      r_teclado  <= 1'b0;
      r_display  <= 1'b0;
      r_setup_on <= 1'b0;
      r_bip      <= 1'b0;
      r_bcd      <= '1;
    end else begin
      r_estado   <= w_prox;
      r_falhas   <= w_falhas_n;
      r_tmr      <= w_tmr_n;
      r_rem      <= w_rem_n;
      r_master   <= w_master_n;
      if (r_estado == SETUP && data_setup_ok) r_setup <= data_setup_new;
      r_tranca   <= !(w_prox == DESTRAVADO_FECHADO || w_prox == PORTA_ABERTA ||
                      w_prox == SETUP);
      r_teclado  <= (w_prox == TRAVADO);
      r_display  <= (w_prox == BLOQUEADO);
      r_setup_on <= (w_prox == SETUP);
      r_bip      <= (w_prox == PORTA_ABERTA) && r_setup.bip_status &&
                    (w_tmr_n >= r_setup.bip_time);
      r_bcd      <= w_bcd_n;
    end
  end

`ifdef ESCALONAMENTO_BLOQUEIO_EN
  always_ff @(posedge clk) begin
    if (w_rst) r_n_bloq <= 2'd0;
    else       r_n_bloq <= w_n_bloq_n;
  end
`endif

  assign tranca     = r_tranca;
  assign teclado_en = r_teclado;
  assign display_en = r_display;
  assign setup_on   = r_setup_on;
  assign bip        = r_bip;
  assign bcd_pac    = r_bcd;

endmodule

`default_nettype wire

// File: doc/operacional_multi.md
Name: operacional_multi

Overview:
Parametrised operational controller for the electronic door lock. It is the successor of the single-password operacional block.
- Supports up to N_SENHAS user passwords plus a master password, with a configurable password length.
- Locks out the keypad for a timed period after MAX_TENTATIVAS consecutive wrong entries and shows a BCD countdown.
- Sits between the keypad/debounce front end, the setup block and the lock actuator, buzzer and display.

Parameters:
N_SENHAS, 2, number of active user password slots (1..N_SENHAS_MAX).
N_DIGITOS, 4, digits compared per password (4..N_DIGITOS_MAX); higher digits are ignored.
MAX_TENTATIVAS, 3, consecutive failures that trigger lockout (1..15).
BLOQ_CICLOS, 30000, base lockout duration in clock cycles.
UNID_CICLOS, 1000, cycles per displayed countdown unit.
TRANCA_AUT_DEF, 5000, reset default for the auto-lock time, in cycles.
BIP_TIME_DEF, 5000, reset default for the door-open alarm delay, in cycles.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-low
sensor_contato  in  1  1 = door closed
botao_interno  in  1  inside unlock button, debounced level
botao_bloqueio  in  1  immediate relock request
botao_config  in  1  enter setup request
data_setup_new  in  setupPac_t  new configuration
data_setup_ok  in  1  one-cycle strobe qualifying data_setup_new
digitos_value  in  senhaPac_t  entered password, unused digits = 4'hF
digitos_valid  in  1  one-cycle strobe qualifying digitos_value
bcd_pac  out  bcdPac_t  display digits
teclado_en  out  1  keypad enable
display_en  out  1  display enable
setup_on  out  1  setup mode active
tranca  out  1  1 = locked
bip  out  1  buzzer

Behaviour:
- All outputs registered. While rst=0 and on the first edge after release:
  - tranca=1, bip=0, setup_on=0, display_en=0, teclado_en=0, bcd_pac all 4'hF.
  - Failure and lockout counters are cleared.
  - Setup register loads defaults: master=1234, user slots disabled (all 4'hF), bip_status=1, times = *_DEF.
- Reset asserted in any state aborts the current operation.
- States:
  - TRAVADO: tranca=1, teclado_en=1.
  - BLOQUEADO: tranca=1, teclado_en=0, display_en=1.
  - DESTRAVADO_FECHADO: tranca=0.
  - PORTA_ABERTA: tranca=0.
  - SETUP: setup_on=1, tranca=0.
- Output latency is one edge: an input sampled on edge k is reflected in outputs after edge k.
- TRAVADO:
  - botao_interno=1 -> DESTRAVADO_FECHADO.
  - digitos_valid with a match (master, or any enabled slot < N_SENHAS, on digits 0..N_DIGITOS-1) -> DESTRAVADO_FECHADO, failure counter cleared.
  - Mismatch increments the failure counter; reaching MAX_TENTATIVAS -> BLOQUEADO, failure counter cleared.
  - botao_interno and digitos_valid in the same cycle: button wins, digits discarded, counter unchanged.
  - sensor_contato=0 while locked is ignored.
- BLOQUEADO:
  - Countdown of the lockout duration (see Optional Feature); at zero -> TRAVADO.
  - digitos_valid is ignored.
  - botao_interno -> DESTRAVADO_FECHADO; countdown abandoned, escalation count kept.
  - bcd_pac digit1:digit0 = ceil(remaining/UNID_CICLOS), clamped to 99; other digits 4'hF.
- DESTRAVADO_FECHADO:
  - Auto-lock counter counts tranca_aut_time cycles -> TRAVADO.
  - sensor_contato=0 -> PORTA_ABERTA.
  - botao_bloqueio -> TRAVADO on the next edge.
  - botao_config -> SETUP, but only if the last unlock was by the master password; otherwise ignored.
  - Priority: botao_bloqueio > sensor_contato > botao_config > timer.
- PORTA_ABERTA:
  - Counts up; when it reaches bip_time and bip_status=1, bip=1 until the door closes.
  - sensor_contato=1 -> DESTRAVADO_FECHADO, bip=0, auto-lock timer restarts.
- SETUP: data_setup_ok latches data_setup_new -> DESTRAVADO_FECHADO with the timer restarted. Any other input is ignored.

Optional Feature:
Macro ESCALONAMENTO_BLOQUEIO_EN.
- Defined: lockout duration = BLOQ_CICLOS << min(n_bloq,3). n_bloq is a 2-bit saturating count of lockouts since the last successful password unlock, cleared by a password match or reset.
- Undefined: duration is always BLOQ_CICLOS and n_bloq logic is absent.

Decomposition:
- Package fechadura_pkg holds:
  - N_SENHAS_MAX=4, N_DIGITOS_MAX=12.
  - senhaPac_t: 12 digits x 4 bits, digit0 in [3:0].
  - bcdPac_t: 6 digits x 4 bits.
  - setupPac_t: bip_status, 16-bit bip_time, 16-bit tranca_aut_time, senha_master, senha_usr[N_SENHAS_MAX].
  - The state enum.
- One sub-module, bin2bcd_2dig: 7-bit binary clamped to 99 -> two BCD digits, combinational.

Test Plan:
(All scenarios use N_DIGITOS=4, MAX_TENTATIVAS=3, BLOQ_CICLOS=20, UNID_CICLOS=1, TRANCA_AUT_DEF=10.)
- Reset release, 2 edges -> tranca=1, teclado_en=1; botao_interno=1 for 1 edge -> tranca=0; 10 cycles closed -> tranca=1.
- digitos 1234 valid -> tranca=0. Relock, then 0000 x3 -> BLOQUEADO with display_en=1, bcd_pac digit1:0 = 2,0, counting down to 0,0; then tranca=1, teclado_en=1.
- With escalation defined: second lockout without an intervening password match lasts 40 cycles (bcd_pac starts at 40); undefined: 20.
- Unlock with master, botao_config -> setup_on=1. Setup strobe with slot1=5678 -> setup_on=0. Relock, 5678 accepted; with N_SENHAS=1 same slot rejected.
- Unlocked, sensor_contato=0 for bip_time=10 -> bip=1 at cycle 10; door closes -> bip=0 and auto-lock restarts.
- digitos_valid(1234) and botao_interno in the same cycle while locked -> unlock, failure count 0. rst=0 during BLOQUEADO -> tranca=1, display_en=0 next edge.
